fifo_sr_qos: RTL and testbench



---
 rtl/fifo_sr_qos_pkg.sv | 17 +
 rtl/fifo_free_list.sv | 63 ++++++
 rtl/fifo_sr_qos.sv | 169 ++++++++++++++++
 tb/tb_fifo_sr_qos.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sr_qos_pkg.sv
// Shared definitions for the shared-buffer multi-flux FIFO: sizing helpers,
// the reservation accounting function and the occupancy accumulator type.
package fifo_sr_qos_pkg;

  // Accumulator wide enough to add up every per-flux count plus the free count.
  typedef logic [15:0] occ_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Entries still owed to one flux under its guaranteed reservation.
  function automatic int unused_reserve(input int cnt, input int reserve);
    return (cnt < reserve) ? (reserve - cnt) : 0;
  endfunction

endpackage

// File: rtl/fifo_free_list.sv
// Circular FIFO of unallocated data-RAM addresses. Reset loads it full with
// addresses 0..DEPTH-1 in ascending order.
module fifo_free_list
  import fifo_sr_qos_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = clog2_min1(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] slot_q [DEPTH];
  logic [ADDR_W-1:0] slot_d [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  assign do_pop   = pop && (count_q != '0);
  assign pop_addr = slot_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      slot_d[wr_ptr_q] = push_addr;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= ADDR_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= CNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/fifo_sr_qos.sv
// Shared-buffer FIFO: FLUX linked-list queues over one DEPTH-entry RAM, with
// per-flux reservations, tagged FWFT read port and sticky error flags.
module fifo_sr_qos
  import fifo_sr_qos_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  parameter  int FLUX       = 4,
  parameter  int RESERVE    = 1,
  localparam int TAG_W      = clog2_min1(FLUX),
  localparam int ADDR_W     = clog2_min1(DEPTH),
  localparam int CNT_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [FLUX-1:0]       wr_full,
  input  logic                  rd_en,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [FLUX-1:0]       rd_empty,
  output logic [FLUX*CNT_W-1:0] flux_cnt,
  output logic [CNT_W-1:0]      free_cnt,
  input  logic                  clr_err,
  output logic                  err_ovf,
  output logic                  err_udf
);

  if (FLUX * RESERVE > DEPTH) begin : g_bad_reserve
    $fatal(1, "fifo_sr_qos: FLUX*RESERVE must not exceed DEPTH");
  end
  if ((1 << ADDR_W) != DEPTH) begin : g_bad_depth
    $fatal(1, "fifo_sr_qos: DEPTH must be a power of two");
  end

  logic [ADDR_W-1:0]     head_q [FLUX];
  logic [ADDR_W-1:0]     head_d [FLUX];
  logic [ADDR_W-1:0]     tail_q [FLUX];
  logic [ADDR_W-1:0]     tail_d [FLUX];
  logic [CNT_W-1:0]      cnt_q  [FLUX];
  logic [CNT_W-1:0]      cnt_d  [FLUX];
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_udf_q, err_udf_d;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]     next_mem [DEPTH];

  logic [CNT_W-1:0]      free_cnt_w;
  logic [ADDR_W-1:0]     alloc_addr;
  int                    unused_res;
  int                    shared_cnt;
  logic                  wr_sel_full, wr_sel_nonempty, rd_sel_empty;
  logic [ADDR_W-1:0]     wr_tail, rd_head;
  logic                  wr_acc, rd_acc;
  logic [FLUX-1:0]       wr_hit, rd_hit;

  // Admission sees registered state only; a same-cycle pop frees nothing yet.
  always_comb begin
    unused_res = 0;
    for (int f = 0; f < FLUX; f++) unused_res += unused_reserve(int'(cnt_q[f]), RESERVE);
    shared_cnt = int'(free_cnt_w) - unused_res;
  end

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_flux
    assign rd_empty[gi]                 = (cnt_q[gi] == '0);
    assign wr_full[gi]                  = (int'(cnt_q[gi]) < RESERVE) ? (free_cnt_w == '0)
                                                                      : (shared_cnt <= 0);
    assign flux_cnt[gi*CNT_W +: CNT_W]  = cnt_q[gi];
    assign wr_hit[gi]                   = wr_acc && (wr_tag == TAG_W'(gi));
    assign rd_hit[gi]                   = rd_acc && (rd_tag == TAG_W'(gi));
  end

  always_comb begin
    wr_sel_full     = 1'b1;
    wr_sel_nonempty = 1'b0;
    wr_tail         = '0;
    rd_sel_empty    = 1'b1;
    rd_head         = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (wr_tag == TAG_W'(f)) begin
        wr_sel_full     = wr_full[f];
        wr_sel_nonempty = !rd_empty[f];
        wr_tail         = tail_q[f];
      end
      if (rd_tag == TAG_W'(f)) begin
        rd_sel_empty = rd_empty[f];
        rd_head      = head_q[f];
      end
    end
  end

  assign wr_acc  = wr_en && !wr_sel_full;
  assign rd_acc  = rd_en && !rd_sel_empty;
  assign rd_data = data_mem[rd_head];

  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      head_d[f] = head_q[f];
      tail_d[f] = tail_q[f];
      if (rd_hit[f]) head_d[f] = next_mem[head_q[f]];
      if (wr_hit[f]) begin
        tail_d[f] = alloc_addr;
        // Queue is (or is about to become) empty: the new entry is the head.
        if (cnt_q[f] == '0 || (rd_hit[f] && cnt_q[f] == CNT_W'(1))) head_d[f] = alloc_addr;
      end
      cnt_d[f] = cnt_q[f] + CNT_W'(wr_hit[f]) - CNT_W'(rd_hit[f]);
    end
    err_ovf_d = clr_err ? 1'b0 : (err_ovf_q | (wr_en & wr_sel_full));
    err_udf_d = clr_err ? 1'b0 : (err_udf_q | (rd_en & rd_sel_empty));
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      data_mem[alloc_addr] <= wr_data;
      if (wr_sel_nonempty) next_mem[wr_tail] <= alloc_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        head_q[f] <= '0;
        tail_q[f] <= '0;
        cnt_q[f]  <= '0;
      end
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        head_q[f] <= head_d[f];
        tail_q[f] <= tail_d[f];
        cnt_q[f]  <= cnt_d[f];
      end
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  fifo_free_list #(.DEPTH(DEPTH)) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_acc),
    .push_addr (rd_head),
    .pop       (wr_acc),
    .pop_addr  (alloc_addr),
    .count     (free_cnt_w)
  );

  assign free_cnt = free_cnt_w;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

  occ_t occ_total;
  always_comb begin
    occ_total = occ_t'(free_cnt_w);
    for (int f = 0; f < FLUX; f++) occ_total += occ_t'(cnt_q[f]);
  end

  a_conserve: assert property (@(posedge clk) disable iff (rst)
    occ_total == occ_t'(DEPTH));

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_cnt_chk
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
      cnt_q[gi] <= CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_fifo_sr_qos.sv
// Directed plus randomized bench for fifo_sr_qos against a queue-level model.
module tb_fifo_sr_qos;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FLUX  = 4;
  localparam int RES   = 1;
  localparam int TAG_W = 2;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en;
  logic [TAG_W-1:0]      wr_tag;
  logic [DW-1:0]         wr_data;
  logic [FLUX-1:0]       wr_full;
  logic                  rd_en;
  logic [TAG_W-1:0]      rd_tag;
  logic [DW-1:0]         rd_data;
  logic [FLUX-1:0]       rd_empty;
  logic [FLUX*CNT_W-1:0] flux_cnt;
  logic [CNT_W-1:0]      free_cnt;
  logic                  clr_err;
  logic                  err_ovf;
  logic                  err_udf;

  fifo_sr_qos #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX), .RESERVE(RES)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data), .wr_full(wr_full),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_data(rd_data), .rd_empty(rd_empty),
    .flux_cnt(flux_cnt), .free_cnt(free_cnt),
    .clr_err(clr_err), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  // Reference model: each flux is an ordered list of payloads.
  logic [7:0] mdat [FLUX][DEPTH];
  int         mcnt [FLUX];
  bit         m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic int m_free();
    int s = DEPTH;
    for (int f = 0; f < FLUX; f++) s -= mcnt[f];
    return s;
  endfunction

  function automatic bit m_full(input int f);
    int owed = 0;
    for (int g = 0; g < FLUX; g++) if (mcnt[g] < RES) owed += RES - mcnt[g];
    if (mcnt[f] < RES) return m_free() == 0;
    return (m_free() - owed) == 0;
  endfunction

  task automatic m_clear();
    for (int f = 0; f < FLUX; f++) mcnt[f] = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic check_outputs(input int rt);
    logic [FLUX-1:0] ef, ee;
    for (int f = 0; f < FLUX; f++) begin
      ef[f] = m_full(f);
      ee[f] = (mcnt[f] == 0);
      check("flux_cnt", 32'(flux_cnt[f*CNT_W +: CNT_W]), mcnt[f]);
    end
    check("wr_full", 32'(wr_full), 32'(ef));
    check("rd_empty", 32'(rd_empty), 32'(ee));
    check("free_cnt", 32'(free_cnt), m_free());
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_udf", 32'(err_udf), 32'(m_udf));
    if (mcnt[rt] != 0) check("rd_data", 32'(rd_data), 32'(mdat[rt][0]));
  endtask

  // One clock of traffic: drive, check pre-edge outputs, clock, update model.
  task automatic step(input int we, input int wt, input int wd,
                      input int re, input int rt, input int ce);
    bit wacc, racc, wref, rref;
    wr_en   = (we != 0);
    wr_tag  = TAG_W'(wt);
    wr_data = DW'(wd);
    rd_en   = (re != 0);
    rd_tag  = TAG_W'(rt);
    clr_err = (ce != 0);
    #1;
    check_outputs(rt);
    wref = (we != 0) && m_full(wt);
    rref = (re != 0) && (mcnt[rt] == 0);
    wacc = (we != 0) && !wref;
    racc = (re != 0) && !rref;
    $display("[TB] cyc=%0d wr=%0d tag=%0d data=%02h acc=%0d rd=%0d tag=%0d acc=%0d clr=%0d",
             n_cyc, we, wt, wd & 8'hFF, wacc, re, rt, racc, ce);
    @(posedge clk);
    n_cyc++;
    if (racc) begin
      for (int i = 0; i < DEPTH - 1; i++) mdat[rt][i] = mdat[rt][i+1];
      mcnt[rt]--;
    end
    if (wacc) begin
      mdat[wt][mcnt[wt]] = 8'(wd);
      mcnt[wt]++;
    end
    m_ovf = (ce != 0) ? 1'b0 : (m_ovf | wref);
    m_udf = (ce != 0) ? 1'b0 : (m_udf | rref);
    #2;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_tag = 0; wr_data = 0;
    rd_en = 0; rd_tag = 0; clr_err = 0;
    m_clear();
    #12 rst = 1'b0;
    @(posedge clk); #2;

    // Reset state
    step(0, 0, 0, 0, 0, 0);

    // Single flux order: A0, A1, A2 out in order
    step(1, 2, 'hA0, 0, 2, 0);
    step(1, 2, 'hA1, 0, 2, 0);
    step(1, 2, 'hA2, 0, 2, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 2, 0);

    // Reservation: five entries in flux 0 exhaust the shared pool
    for (int k = 0; k < 5; k++) step(1, 0, 'h50 + k, 0, 0, 0);
    step(1, 1, 'h61, 0, 0, 0);
    step(1, 0, 'h5F, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);

    // Interleaved fluxes, drained out of order
    step(1, 0, 'h10, 0, 3, 0);
    step(1, 3, 'h30, 0, 3, 0);
    step(1, 0, 'h11, 0, 3, 0);
    step(1, 3, 'h31, 0, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Same-flux write and read with one entry queued
    step(1, 1, 'h55, 0, 1, 0);
    step(1, 1, 'h66, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Underflow flag and its clear
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 2, 1);
    step(0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 0, 2, 0);

    // Fill, then asynchronous reset between edges
    for (int f = 0; f < FLUX; f++)
      for (int k = 0; k < 2; k++) step(1, f, 'hC0 + f*2 + k, 0, 0, 0);
    step(1, 2, 'hEE, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_free_cnt", 32'(free_cnt), DEPTH);
    check("rst_rd_empty", 32'(rd_empty), 32'hF);
    check("rst_wr_full", 32'(wr_full), 32'h0);
    check("rst_flux_cnt", 32'(flux_cnt), 32'h0);
    check("rst_err_ovf", 32'(err_ovf), 32'h0);
    m_clear();
    @(posedge clk); #2;
    rst = 1'b0;
    step(1, 1, 'h77, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 6) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 255),
           ($urandom_range(0, 9) < 5) ? 1 : 0, $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0) ? 1 : 0);
    end
    for (int n = 0; n < 40; n++) step(0, 0, 0, 1, n % FLUX, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
